local_traffic_gen: RTL and testbench
====================================

// Module: local_traffic_gen
// PURPOSE
//  Local-port network interface / traffic endpoint for one async_router tile.
//  Source side injects flits into the router's parallel local input (rx_data_l / rx_valid_l, backpressure = rx_busy[LOCAL]).
//  Sink side consumes flits from the router's local output (tx_data_l / tx_valid_l) and checks their destination.
//  Keeps sent/received/error statistics for mesh characterisation benches.
// PARAMETERS
//  ADDR_W  `ADDR_SZ                        router address width (flit LSBs)
//  PL_W    `PL_SZ                          payload width
//  HDR_W   `HDR_SZ                         header width (flit MSBs)
//  FLIT_W  `HDR_SZ+`PL_SZ+`ADDR_SZ         flit width = HDR_W+PL_W+ADDR_W
// PORTS
//  clk        in   1       tile local clock (same clk as the router)
//  reset      in   1       asynchronous, active-high
//  id         in   ADDR_W  own router address
//  enable     in   1       injection enable
//  gap        in   8       idle cycles between accepted flits (0 = back-to-back)
//  max_flits  in   16      flits to send per run; 0 = unlimited
//  dest_in    in   ADDR_W  fixed destination (used when TG_RAND_DEST_EN undefined)
//  tx_data    out  FLIT_W  flit to router rx_data_l
//  tx_valid   out  1       to router rx_valid_l
//  tx_busy    in   1       router rx_busy[LOCAL] (local FIFO full)
//  rx_data    in   FLIT_W  router tx_data_l
//  rx_valid   in   1       router tx_valid_l
//  rx_busy    out  1       to router tx_busy[LOCAL]; tied 0 (sink always ready)
//  done       out  1       max_flits reached (sticky until reset or enable falls)
//  sent_count out  16      flits accepted by router
//  recv_count out  16      flits received
//  err_count  out  16      received flits with addr != id
// BEHAVIOUR
//  Flit layout: {hdr = HDR_W'b0, payload = seq[PL_W-1:0], addr = dest}; seq = sent_count zero-extended/truncated to PL_W.
//  Transfer rule (source): flit accepted in any cycle with tx_valid=1 and tx_busy=0; no separate ack.
//  Once tx_valid rises, tx_data and tx_valid stay stable until the flit is accepted; never retracted.
//  FSM (registered): IDLE, GAP, OFFER.
//   IDLE:  enable=1 and !done -> OFFER if gap==0, else GAP with gcnt<=gap.
//   GAP:   gcnt decrements each cycle; gcnt==1 -> OFFER; enable=0 -> IDLE.
//   OFFER: tx_valid=1. On accept: sent_count+1 (wraps mod 2^16), seq advances.
//          If max_flits!=0 and the new sent_count==max_flits -> done=1, IDLE.
//          Else if enable=0 -> IDLE; else if gap==0 -> stay in OFFER with the next flit in the next cycle; else GAP.
//          enable=0 while unaccepted -> keep offering until accepted.
//  gap is sampled when GAP is entered; later changes take effect at the next entry.
//  done clears when enable=0; counters are not cleared (reset only).
//  tx_valid is registered: first flit appears 1 cycle after enable is seen in IDLE.
//  Sink: every cycle with rx_valid=1 is one flit; recv_count+1 (wraps).
//        If rx_data[ADDR_W-1:0]!=id, err_count+1, saturating at 16'hFFFF.
//  Send and receive in the same cycle are independent; both counters update.
//  Reset values: state IDLE, tx_valid 0, tx_data 0, rx_busy 0, done 0, all counters 0, LFSR 16'hACE1.
//  Reset mid-offer drops the pending flit immediately; the router must not see valid after reset asserts.
// CONFIGURATION
//  TG_RAND_DEST_EN defined:
//   - 16-bit Fibonacci LFSR, taps 16,14,13,11, seeded 16'hACE1; advances once per accepted flit.
//   - dest = lfsr[ADDR_W-1:0]; dest_in ignored.
//  TG_RAND_DEST_EN undefined:
//   - no LFSR logic; dest = dest_in, sampled when the flit is loaded into OFFER.
// TESTING
//  1 reset mid-run: enable=1, gap=0, tx_busy=0, max_flits=0, assert reset during OFFER
//    -> tx_valid=0 same cycle, all counters 0, state IDLE after release.
//  2 back-to-back: id=5, dest_in=3, gap=0, max_flits=4, tx_busy=0
//    -> 4 consecutive valid cycles, payloads 0..3, addr=3, then done=1, sent_count=4.
//  3 gap timing: gap=3, max_flits=3 -> accepted flits spaced exactly 4 cycles apart; done after 3rd.
//  4 backpressure: tx_busy=1 for 10 cycles during OFFER
//    -> tx_valid and tx_data held constant for all 10 cycles; sent_count unchanged; increments on 1st cycle tx_busy=0.
//  5 sink check: rx_valid pulses with addr 5,5,2 (id=5)
//    -> recv_count=3, err_count=1; concurrent sends still counted.
//  6 wrap/saturate: force counters to 16'hFFFF, one send + one bad receive
//    -> sent_count=0, recv_count=0, err_count stays 16'hFFFF.
//    With TG_RAND_DEST_EN: first two dest = 16'hACE1 and 16'h5670, masked to ADDR_W.

Source files
------------

// File: rtl/local_traffic_gen.sv
// local_traffic_gen: traffic endpoint for one async_router tile's local port.
// Injects sequenced flits into the router, counts flits received at the
// local output, and flags received flits that are not addressed to this tile.
// Optional feature macro: TG_RAND_DEST_EN (LFSR-driven destinations).
// Width macros ADDR_SZ / PL_SZ / HDR_SZ default below if not set externally.

`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif
`ifndef PL_SZ
`define PL_SZ 8
`endif
`ifndef HDR_SZ
`define HDR_SZ 4
`endif

module local_traffic_gen #(
    parameter int unsigned ADDR_W = `ADDR_SZ,
    parameter int unsigned PL_W   = `PL_SZ,
    parameter int unsigned HDR_W  = `HDR_SZ,
    parameter int unsigned FLIT_W = HDR_W + PL_W + ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] id,
    input  logic              enable,
    input  logic [7:0]        gap,
    input  logic [15:0]       max_flits,
    input  logic [ADDR_W-1:0] dest_in,
    output logic [FLIT_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    input  logic [FLIT_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_busy,
    output logic              done,
    output logic [15:0]       sent_count,
    output logic [15:0]       recv_count,
    output logic [15:0]       err_count
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        OFFER = 2'd2
    } state_t;

    state_t           state;
    logic [GAP_W-1:0] gcnt;
    logic             accept;
    logic [CNT_W-1:0] sent_nxt;
    logic [ADDR_W-1:0] dest_cur;
    logic [ADDR_W-1:0] dest_adv;
    logic             unused_rx;

    // Build a flit: zero header, sequence number payload, destination address
    function automatic logic [FLIT_W-1:0] make_flit(input logic [CNT_W-1:0] seq,
                                                     input logic [ADDR_W-1:0] dst);
        logic [PL_W-1:0] pl;
        pl = PL_W'(seq);
        return {{HDR_W{1'b0}}, pl, dst};
    endfunction

    assign accept    = (state == OFFER) && !tx_busy;
    assign sent_nxt  = sent_count + 16'd1;
    assign rx_busy   = 1'b0;
    assign unused_rx = ^rx_data[FLIT_W-1:ADDR_W];

`ifdef TG_RAND_DEST_EN
    logic [15:0] lfsr;
    logic [15:0] lfsr_nxt;

    // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shift-right form
    assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign dest_cur = lfsr[ADDR_W-1:0];
    assign dest_adv = lfsr_nxt[ADDR_W-1:0];

    logic unused_dest;
    assign unused_dest = ^dest_in;

    // LFSR steps once per flit accepted by the router
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= 16'hACE1;
        end else if (accept) begin
            lfsr <= lfsr_nxt;
        end
    end
`else
    assign dest_cur = dest_in;
    assign dest_adv = dest_in;
`endif

    // Source FSM: pacing, offer/hold under backpressure, run length and done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gcnt       <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            done       <= 1'b0;
            sent_count <= '0;
        end else begin
            if (!enable) begin
                done <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (enable && !done) begin
                        if (gap == 8'd0) begin
                            state    <= OFFER;
                            tx_valid <= 1'b1;
                            tx_data  <= make_flit(sent_count, dest_cur);
                        end else begin
                            state <= GAP;
                            gcnt  <= gap;
                        end
                    end
                end
                GAP: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (gcnt == 8'd1) begin
                        state    <= OFFER;
                        tx_valid <= 1'b1;
                        tx_data  <= make_flit(sent_count, dest_cur);
                    end else begin
                        gcnt <= gcnt - 8'd1;
                    end
                end
                OFFER: begin
                    if (!tx_busy) begin
                        sent_count <= sent_nxt;
                        if ((max_flits != 16'd0) && (sent_nxt == max_flits)) begin
                            done     <= 1'b1;
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                        end else if (!enable) begin
                            state    <= IDLE;
                            tx_valid <= 1'b0;
                        end else if (gap == 8'd0) begin
                            tx_data <= make_flit(sent_nxt, dest_adv);
                        end else begin
                            state    <= GAP;
                            gcnt     <= gap;
                            tx_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                end
            endcase
        end
    end

    // Sink: count every delivered flit, saturating count of misrouted ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            recv_count <= '0;
            err_count  <= '0;
        end else if (rx_valid) begin
            recv_count <= recv_count + 16'd1;
            if ((rx_data[ADDR_W-1:0] != id) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_local_traffic_gen.sv
// Self-checking bench for local_traffic_gen: scoreboarded source flits,
// table-driven sink vectors, and directed multi-cycle corner sequences.
`timescale 1ns/1ps

module tb_local_traffic_gen;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned PL_W   = 8;
    localparam int unsigned HDR_W  = 4;
    localparam int unsigned FLIT_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] id;
    logic              enable;
    logic [7:0]        gap;
    logic [15:0]       max_flits;
    logic [ADDR_W-1:0] dest_in;
    logic [FLIT_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_busy;
    logic [FLIT_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_busy;
    logic              done;
    logic [15:0]       sent_count;
    logic [15:0]       recv_count;
    logic [15:0]       err_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit sb_on  = 1'b0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [FLIT_W-1:0] exp_q[$];
    int acc_cyc[$];

    typedef struct {
        logic        v;
        logic [3:0]  addr;
        logic [15:0] exp_recv;
        logic [15:0] exp_err;
    } sink_vec_t;
    sink_vec_t vecs[4];

    local_traffic_gen #(
        .ADDR_W(ADDR_W), .PL_W(PL_W), .HDR_W(HDR_W), .FLIT_W(FLIT_W)
    ) dut (
        .clk(clk), .reset(reset), .id(id), .enable(enable), .gap(gap),
        .max_flits(max_flits), .dest_in(dest_in), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_busy(tx_busy), .rx_data(rx_data),
        .rx_valid(rx_valid), .rx_busy(rx_busy), .done(done),
        .sent_count(sent_count), .recv_count(recv_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    // Expected flit for sequence number seq; consumes one model destination
    task automatic push_exp(input int seq, output logic [FLIT_W-1:0] f);
        logic [3:0] d;
`ifdef TG_RAND_DEST_EN
        d = m_lfsr[3:0];
        m_lfsr = lfsr_adv(m_lfsr);
`else
        d = dest_in;
`endif
        f = {4'h0, 8'(seq), d};
        exp_q.push_back(f);
    endtask

    // Scoreboard: every accepted flit must match the next expected one
    always @(negedge clk) begin
        if (sb_on && tx_valid && !tx_busy) begin
            acc_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("sb_extra_flit", 32'(tx_data), 32'hFFFF_FFFF);
            else check("sb_flit", 32'(tx_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; tx_busy = 1'b0; rx_valid = 1'b0;
        gap = 8'd0; max_flits = 16'd0;
        step(); step();
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        exp_q.delete();
        acc_cyc.delete();
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(done), 32'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FLIT_W-1:0] f;
        logic [FLIT_W-1:0] first;

        vecs[0] = '{1'b1, 4'd5, 16'd1, 16'd0};
        vecs[1] = '{1'b1, 4'd5, 16'd2, 16'd0};
        vecs[2] = '{1'b0, 4'd2, 16'd2, 16'd0};
        vecs[3] = '{1'b1, 4'd2, 16'd3, 16'd1};

        id = 4'd5; dest_in = 4'd3; rx_data = '0;
        do_reset();

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        check("rst_counts", {sent_count, recv_count ^ err_count}, 32'd0);

        // Reset mid-run drops the pending flit at once
        enable = 1'b1;
        step(); step(); step();
        check("midrun_sent", 32'(sent_count), 32'd2);
        check("midrun_valid", 32'(tx_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("midrun_rst_valid", 32'(tx_valid), 32'd0);
        check("midrun_rst_sent", 32'(sent_count), 32'd0);
        step();
        reset = 1'b0;
        m_lfsr = 16'hACE1;
        step();
`ifdef TG_RAND_DEST_EN
        f = {4'h0, 8'h00, m_lfsr[3:0]};
`else
        f = {4'h0, 8'h00, dest_in};
`endif
        check("midrun_restart_valid", 32'(tx_valid), 32'd1);
        check("midrun_restart_data", 32'(tx_data), 32'(f));

        // Back-to-back run of 4 flits
        do_reset();
        sb_on = 1'b1;
        for (int i = 0; i < 4; i++) push_exp(i, f);
        max_flits = 16'd4;
        enable = 1'b1;
        wait_done("b2b_done", 20);
        step(); step();
        check("b2b_sent", 32'(sent_count), 32'd4);
        check("b2b_accepts", 32'(acc_cyc.size()), 32'd4);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            check("b2b_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd1);
        check("b2b_done_sticky", 32'(done), 32'd1);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        enable = 1'b0;
        step();
        check("b2b_done_clear", 32'(done), 32'd0);
        check("b2b_sent_kept", 32'(sent_count), 32'd4);

        // Gap timing: gap=3 spaces accepts 4 cycles apart
        do_reset();
        for (int i = 0; i < 3; i++) push_exp(i, f);
        gap = 8'd3; max_flits = 16'd3;
        enable = 1'b1;
        wait_done("gap_done", 40);
        check("gap_sent", 32'(sent_count), 32'd3);
        check("gap_accepts", 32'(acc_cyc.size()), 32'd3);
        for (int i = 0; i + 1 < acc_cyc.size(); i++)
            check("gap_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd4);
        check("gap_sb_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: flit held for 10 busy cycles, kept after enable falls
        do_reset();
        push_exp(0, first);
        tx_busy = 1'b1;
        enable = 1'b1;
        step();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", {15'd0, tx_valid, tx_data}, {15'd0, 1'b1, first});
            check("bp_sent", 32'(sent_count), 32'd0);
            step();
        end
        tx_busy = 1'b0;
        step();
        check("bp_sent_after", 32'(sent_count), 32'd1);
        check("bp_valid_drop", 32'(tx_valid), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // Sink vectors with concurrent sends
        do_reset();
        for (int i = 0; i < 3; i++) push_exp(i, f);
        max_flits = 16'd3;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_valid = vecs[i].v;
            rx_data = {4'($urandom), 8'($urandom), vecs[i].addr};
            step();
            check("sink_recv", 32'(recv_count), 32'(vecs[i].exp_recv));
            check("sink_err", 32'(err_count), 32'(vecs[i].exp_err));
        end
        rx_valid = 1'b0;
        wait_done("sink_tx_done", 10);
        check("sink_tx_sent", 32'(sent_count), 32'd3);
        check("sink_sb_empty", 32'(exp_q.size()), 32'd0);
        sb_on = 1'b0;

        // Wrap and saturation: drive all counters to FFFF, then one more
        do_reset();
        max_flits = 16'hFFFF;
        enable = 1'b1;
        rx_valid = 1'b1;
        rx_data = {4'h0, 8'h00, 4'd2};
        for (int i = 0; i < 65535; i++) step();
        rx_valid = 1'b0;
        wait_done("wrap_done", 50);
        check("wrap_pre_sent", 32'(sent_count), 32'h0000FFFF);
        check("wrap_pre_recv", 32'(recv_count), 32'h0000FFFF);
        check("wrap_pre_err", 32'(err_count), 32'h0000FFFF);
        max_flits = 16'd0;
        enable = 1'b0;
        step();
        check("wrap_done_clear", 32'(done), 32'd0);
        enable = 1'b1;
        rx_valid = 1'b1;
        step();
        enable = 1'b0;
        rx_valid = 1'b0;
        step();
        check("wrap_sent", 32'(sent_count), 32'd0);
        check("wrap_recv", 32'(recv_count), 32'd0);
        check("wrap_err_sat", 32'(err_count), 32'h0000FFFF);
        check("wrap_idle", 32'(tx_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
